fixpdiv_seq: RTL and testbench

- Sequential signed fixed-point divider; inverse operation of the team's fixpmul, using the same IW/FW fixed-point format.
- Computes o = a / b with a radix-2 restoring algorithm over multiple cycles. Uses valid/ready handshakes on both input and output.
- Sits beside fixpmul in the MCMC datapath, for normalisation and acceptance-ratio computation.

---
 rtl/fixpdiv_seq.sv | 179 +++++++++++++++++
 tb/tb_fixpdiv_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fixpdiv_seq.sv
// Sequential signed fixed-point divider (radix-2 restoring), o = a / b.
// Operands and result share the IW.FW two's-complement format of fixpmul.
// Latency: input accepted at edge k gives out_valid from edge k+N+1 (N = W+FW).
// Optional macro FIXPDIV_ROUND_EN: round to nearest (ties away from zero)
// instead of truncating toward zero.
module fixpdiv_seq #(
    parameter int unsigned IW = 8,
    parameter int unsigned FW = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IW+FW-1:0] a,
    input  logic [IW+FW-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IW+FW-1:0] o,
    output logic             ovf,
    output logic             div0
);

    localparam int unsigned W  = IW + FW;
    localparam int unsigned N  = W + FW;
    localparam int unsigned CW = $clog2(N + 1);

    // Quotient magnitude limits for positive and negative results.
    localparam logic [N:0]   QPos = (N+1)'((64'd1 << (W - 1)) - 64'd1);
    localparam logic [N:0]   QNeg = (N+1)'(64'd1 << (W - 1));
    localparam logic [W-1:0] OMax = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] OMin = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e         r_state, w_state_next;
    logic           r_sa, r_sb;
    logic [W:0]     r_mag_b;
    logic [N-1:0]   r_dvd;
    logic [W-1:0]   r_rem;
    logic [N-1:0]   r_quo;
    logic [CW-1:0]  r_cnt;
    logic [W-1:0]   r_o;
    logic           r_ovf, r_div0;

    logic [W-1:0]   w_mag_a;
    logic [W:0]     w_mag_b;
    logic [W:0]     w_shift;
    logic [W+1:0]   w_diff;
    logic [W-1:0]   w_rem_next;
    logic           w_qbit;
    logic [N:0]     w_q;
    logic           w_neg;
    logic [W-1:0]   w_res_o;
    logic           w_res_ovf, w_res_div0;

    // Magnitudes; |-2^(W-1)| fits as an unsigned W-bit value.
    assign w_mag_a = a[W-1] ? (~a + 1'b1) : a;
    assign w_mag_b = {1'b0, (b[W-1] ? (~b + 1'b1) : b)};

    // One restoring step: shift in the next dividend bit and trial-subtract.
    assign w_shift    = {r_rem, r_dvd[N-1]};
    assign w_diff     = {1'b0, w_shift} - {1'b0, r_mag_b};
    assign w_qbit     = ~w_diff[W+1];
    assign w_rem_next = w_diff[W+1] ? w_shift[W-1:0] : w_diff[W-1:0];

`ifdef FIXPDIV_ROUND_EN
    logic w_round_up;
    // Round half away from zero on the magnitude: 2*rem >= |b|.
    assign w_round_up = ({r_rem, 1'b0} >= r_mag_b);
    assign w_q        = {1'b0, r_quo} + {{N{1'b0}}, w_round_up};
`else
    assign w_q = {1'b0, r_quo};
`endif

    assign w_neg = r_sa ^ r_sb;

    // Sign restoration, saturation and divide-by-zero override of the final quotient.
    always_comb begin
        w_res_o    = '0;
        w_res_ovf  = 1'b0;
        w_res_div0 = 1'b0;
        if (r_mag_b == '0) begin
            w_res_div0 = 1'b1;
            w_res_o    = r_sa ? OMin : OMax;
        end else if (w_neg) begin
            if (w_q > QNeg) begin
                w_res_o   = OMin;
                w_res_ovf = 1'b1;
            end else begin
                w_res_o = ~w_q[W-1:0] + 1'b1;
            end
        end else begin
            if (w_q > QPos) begin
                w_res_o   = OMax;
                w_res_ovf = 1'b1;
            end else begin
                w_res_o = w_q[W-1:0];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        unique case (r_state)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) w_state_next = StRun;
            end
            StRun: begin
                if (r_cnt == '0) w_state_next = StDone;
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Datapath: operand capture, N iteration steps, then result capture on the extra cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_mag_b <= '0;
            r_dvd   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_cnt   <= '0;
            r_o     <= '0;
            r_ovf   <= 1'b0;
            r_div0  <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_sa    <= a[W-1];
                        r_sb    <= b[W-1];
                        r_mag_b <= w_mag_b;
                        r_dvd   <= N'(w_mag_a) << FW;
                        r_rem   <= '0;
                        r_quo   <= '0;
                        r_cnt   <= CW'(N);
                    end
                end
                StRun: begin
                    if (r_cnt != '0) begin
                        r_rem <= w_rem_next;
                        r_quo <= {r_quo[N-2:0], w_qbit};
                        r_dvd <= {r_dvd[N-2:0], 1'b0};
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_o    <= w_res_o;
                        r_ovf  <= w_res_ovf;
                        r_div0 <= w_res_div0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o    = r_o;
    assign ovf  = r_ovf;
    assign div0 = r_div0;

endmodule

// File: tb/tb_fixpdiv_seq.sv
// Self-checking bench for fixpdiv_seq: directed table, randomized stimulus against
// an arithmetic reference model, backpressure and mid-operation reset sequences.
// Instance 0 uses IW=8/FW=0, instance 1 uses IW=4/FW=4 (both W=8).
module tb_fixpdiv_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0]      in_valid  = '0;
    logic [1:0]      out_ready = '0;
    logic [1:0]      in_ready, out_valid, ovf, div0;
    logic [1:0][7:0] a_v = '0;
    logic [1:0][7:0] b_v = '0;
    logic [1:0][7:0] o_v;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fixpdiv_seq #(.IW(8), .FW(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a_v[0]), .b(b_v[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .o(o_v[0]), .ovf(ovf[0]), .div0(div0[0])
    );

    fixpdiv_seq #(.IW(4), .FW(4)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a_v[1]), .b(b_v[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .o(o_v[1]), .ovf(ovf[1]), .div0(div0[1])
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: plain integer division on magnitudes, then sign and saturation (W=8).
    function automatic void model(input int fw, input logic [7:0] ai, input logic [7:0] bi,
                                  output logic [7:0] eo, output logic eovf,
                                  output logic ediv0);
        longint av, bv, ma, mb, num, q, r, res;
        bit neg;
        av = longint'($signed(ai));
        bv = longint'($signed(bi));
        eovf  = 1'b0;
        ediv0 = 1'b0;
        if (bv == 0) begin
            ediv0 = 1'b1;
            eo    = (av < 0) ? 8'h80 : 8'h7F;
        end else begin
            ma  = (av < 0) ? -av : av;
            mb  = (bv < 0) ? -bv : bv;
            num = ma << fw;
            q   = num / mb;
            r   = num % mb;
`ifdef FIXPDIV_ROUND_EN
            if (2 * r >= mb) q = q + 1;
`endif
            neg = (av < 0) != (bv < 0);
            if (neg) begin
                if (q > 128) begin
                    eo = 8'h80; eovf = 1'b1;
                end else begin
                    res = -q;
                    eo  = res[7:0];
                end
            end else if (q > 127) begin
                eo = 8'h7F; eovf = 1'b1;
            end else begin
                eo = q[7:0];
            end
        end
    endfunction

    // Full transaction on one instance; called #1 after a posedge.
    task automatic run_div(input int sel, input logic [7:0] ta, input logic [7:0] tb_,
                           output logic [7:0] ro, output logic rovf, output logic rdiv0,
                           output int lat);
        int g;
        g = 0;
        while (!in_ready[sel] && g < 50) begin
            @(posedge clk); #1; g++;
        end
        a_v[sel] = ta;
        b_v[sel] = tb_;
        in_valid[sel] = 1'b1;
        @(posedge clk); #1;
        in_valid[sel] = 1'b0;
        lat = 0;
        while (!out_valid[sel] && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        ro    = o_v[sel];
        rovf  = ovf[sel];
        rdiv0 = div0[sel];
        out_ready[sel] = 1'b1;
        @(posedge clk); #1;
        out_ready[sel] = 1'b0;
    endtask

    typedef struct {
        int         sel;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] o;
        logic       ovf;
        logic       div0;
    } vec_t;

    initial begin
        vec_t       vecs[$];
        bit         rnd;
        logic [7:0] ro, eo, ta, tb_;
        logic       rovf, rdiv0, eovf, ediv0;
        int         lat, g, sel;

`ifdef FIXPDIV_ROUND_EN
        rnd = 1'b1;
`else
        rnd = 1'b0;
`endif
        vecs.push_back('{0, 8'h0F, 8'h07, 8'h02, 1'b0, 1'b0});
        vecs.push_back('{0, 8'h0F, 8'hEE, rnd ? 8'hFF : 8'h00, 1'b0, 1'b0});
        vecs.push_back('{1, 8'h20, 8'h30, rnd ? 8'h0B : 8'h0A, 1'b0, 1'b0});
        vecs.push_back('{0, 8'h80, 8'hFF, 8'h7F, 1'b1, 1'b0});
        vecs.push_back('{0, 8'h05, 8'h00, 8'h7F, 1'b0, 1'b1});
        vecs.push_back('{0, 8'hFB, 8'h00, 8'h80, 1'b0, 1'b1});
        vecs.push_back('{0, 8'h00, 8'h00, 8'h7F, 1'b0, 1'b1});
        vecs.push_back('{0, 8'h80, 8'h01, 8'h80, 1'b0, 1'b0});
        vecs.push_back('{0, 8'h7F, 8'hFF, 8'h81, 1'b0, 1'b0});
        vecs.push_back('{0, 8'hF9, 8'h02, rnd ? 8'hFC : 8'hFD, 1'b0, 1'b0});
        vecs.push_back('{0, 8'h07, 8'h02, rnd ? 8'h04 : 8'h03, 1'b0, 1'b0});
        vecs.push_back('{0, 8'h64, 8'h03, 8'h21, 1'b0, 1'b0});
        vecs.push_back('{1, 8'h80, 8'h10, 8'h80, 1'b0, 1'b0});
        vecs.push_back('{1, 8'h70, 8'h08, 8'h7F, 1'b1, 1'b0});

        // Reset state of both instances.
        #1;
        for (int s = 0; s < 2; s++) begin
            check("rst_in_ready", in_ready[s], 1'b1);
            check("rst_out_valid", out_valid[s], 1'b0);
            check("rst_o", o_v[s], 8'h00);
            check("rst_ovf", ovf[s], 1'b0);
            check("rst_div0", div0[s], 1'b0);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Directed table.
        foreach (vecs[i]) begin
            run_div(vecs[i].sel, vecs[i].a, vecs[i].b, ro, rovf, rdiv0, lat);
            check($sformatf("vec%0d_o", i), ro, vecs[i].o);
            check($sformatf("vec%0d_ovf", i), rovf, vecs[i].ovf);
            check($sformatf("vec%0d_div0", i), rdiv0, vecs[i].div0);
            check($sformatf("vec%0d_latency", i), lat, (vecs[i].sel == 1) ? 13 : 9);
        end

        // Randomized operands against the reference model.
        for (int i = 0; i < 300; i++) begin
            sel = i % 2;
            ta  = 8'($urandom);
            tb_ = 8'($urandom);
            if (i % 17 == 0) tb_ = 8'h00;
            if (i % 23 == 0) ta = 8'h80;
            if (i % 29 == 0) tb_ = 8'h01;
            model((sel == 1) ? 4 : 0, ta, tb_, eo, eovf, ediv0);
            run_div(sel, ta, tb_, ro, rovf, rdiv0, lat);
            check($sformatf("rnd%0d_o(%0h/%0h)", i, ta, tb_), ro, eo);
            check($sformatf("rnd%0d_ovf", i), rovf, eovf);
            check($sformatf("rnd%0d_div0", i), rdiv0, ediv0);
        end

        // Backpressure: result held in DONE, new operands ignored.
        a_v[0] = 8'h0F; b_v[0] = 8'h07; in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        g = 0;
        while (!out_valid[0] && g < 100) begin
            @(posedge clk); #1; g++;
        end
        check("bp_reach_done", out_valid[0], 1'b1);
        for (int c = 0; c < 20; c++) begin
            a_v[0] = 8'h33; b_v[0] = 8'h01; in_valid[0] = 1'b1;
            @(posedge clk); #1;
            check("bp_o", o_v[0], 8'h02);
            check("bp_flags", {ovf[0], div0[0]}, 2'b00);
            check("bp_out_valid", out_valid[0], 1'b1);
            check("bp_in_ready", in_ready[0], 1'b0);
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        check("bp_release_out_valid", out_valid[0], 1'b0);
        check("bp_release_in_ready", in_ready[0], 1'b1);
        @(posedge clk); #1;
        check("bp_no_stale_accept", in_ready[0], 1'b1);

        // Asynchronous reset four cycles into RUN.
        a_v[0] = 8'h64; b_v[0] = 8'h03; in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid_run_busy", in_ready[0], 1'b0);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid[0], 1'b0);
        check("mid_rst_in_ready", in_ready[0], 1'b1);
        check("mid_rst_o", o_v[0], 8'h00);
        @(posedge clk); #1;
        rst = 1'b0;
        run_div(0, 8'h0F, 8'h07, ro, rovf, rdiv0, lat);
        check("post_rst_o", ro, 8'h02);
        check("post_rst_flags", {rovf, rdiv0}, 2'b00);
        check("post_rst_latency", lat, 9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
